// File: rtl/match_pe_pipeline_pkg.sv
// Shared widths and the leading-equal-byte count for the match PE compare pipeline.
package match_pe_pipeline_pkg;
  localparam int unsigned ADDR_WIDTH         = 32;
  localparam int unsigned MATCH_PE_WIDTH     = 8;
  localparam int unsigned MAX_MATCH_LEN_LOG2 = $clog2(MATCH_PE_WIDTH);
  localparam int unsigned MAX_MATCH_LEN      = MATCH_PE_WIDTH;
  localparam int unsigned LANE_W             = MAX_MATCH_LEN_LOG2;
  localparam int unsigned LEN_W              = MAX_MATCH_LEN_LOG2 + 1;
  localparam int unsigned BEAT_BITS          = MATCH_PE_WIDTH * 8;

  typedef logic [MAX_MATCH_LEN-1:0] eq_vec_t;
  typedef logic [LEN_W-1:0]         match_len_t;

  // Number of consecutive set bits starting at bit 0.
  function automatic match_len_t lead_ones(input eq_vec_t eq);
    match_len_t n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int unsigned k = 0; k < MAX_MATCH_LEN; k++) begin
      run = run & eq[k];
      n   = n + LEN_W'(run);
    end
    return n;
  endfunction
endpackage

// File: rtl/match_pe_window_ram.sv
// Byte-banked ring window: one W-aligned write port, one unaligned W-byte read port.
// Bank reads are registered; the rotation back into address order follows the register.
module match_pe_window_ram
  import match_pe_pipeline_pkg::*;
#(
  parameter int unsigned SIZE_LOG2 = 15
) (
  input  logic                            clk,
  input  logic                            wr_en_i,
  input  logic [SIZE_LOG2-LANE_W-1:0]     wr_row_i,
  input  logic [BEAT_BITS-1:0]            wr_data_i,
  input  logic [SIZE_LOG2-1:0]            rd_addr_i,
  output logic [BEAT_BITS-1:0]            rd_data_c_o
);
  localparam int unsigned ROW_W = SIZE_LOG2 - LANE_W;
  localparam int unsigned ROWS  = 1 << ROW_W;
  localparam int unsigned RSH_W = $clog2(2 * BEAT_BITS);

  logic [BEAT_BITS-1:0]   banks_c;
  logic [2*BEAT_BITS-1:0] dbl_c;
  logic [RSH_W-1:0]       rot_sh_c;
  logic [LANE_W-1:0]      off_q;

  for (genvar b = 0; b < MATCH_PE_WIDTH; b++) begin : g_bank
    logic [7:0]       mem [ROWS];
    logic [7:0]       rd_q;
    logic             wrap_c;
    logic [ROW_W-1:0] rd_row_c;

    // Banks below the start lane hold bytes from the following row.
    assign wrap_c   = LANE_W'(b) < rd_addr_i[LANE_W-1:0];
    assign rd_row_c = rd_addr_i[SIZE_LOG2-1:LANE_W] + ROW_W'(wrap_c);

    always_ff @(posedge clk) begin
      if (wr_en_i) begin
        mem[wr_row_i] <= wr_data_i[8*b +: 8];
      end
      rd_q <= mem[rd_row_c];
    end

    assign banks_c[8*b +: 8] = rd_q;
  end

  always_ff @(posedge clk) begin
    off_q <= rd_addr_i[LANE_W-1:0];
  end

  assign dbl_c       = {banks_c, banks_c};
  assign rot_sh_c    = RSH_W'({off_q, 3'b000});
  assign rd_data_c_o = dbl_c[rot_sh_c +: BEAT_BITS];
endmodule

// File: rtl/match_pe_pipeline.sv
// Fixed-latency compare pipeline: reads W bytes from head and history windows and
// returns the count of leading equal bytes with the beat's idx/last NBPIPE cycles later.
module match_pe_pipeline
  import match_pe_pipeline_pkg::*;
#(
  parameter int unsigned SCOREBOARD_ENTRY_INDEX = 1,
  parameter int unsigned NBPIPE                 = 3,
  parameter int unsigned SIZE_LOG2              = 15,
  parameter              LABEL                  = "unnamed_match_pe",
  parameter int unsigned JOB_PE_IDX             = 0,
  parameter int unsigned MATCH_PE_IDX           = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  input  logic [SCOREBOARD_ENTRY_INDEX-1:0] i_idx,
  input  logic                              i_last,
  input  logic [ADDR_WIDTH-1:0]             i_head_addr,
  input  logic [ADDR_WIDTH-1:0]             i_history_addr,
  output logic                              o_valid,
  output logic                              o_last,
  output logic [SCOREBOARD_ENTRY_INDEX-1:0] o_idx,
  output logic [MAX_MATCH_LEN_LOG2:0]       o_match_len,
  input  logic [ADDR_WIDTH-1:0]             i_write_addr,
  input  logic [BEAT_BITS-1:0]              i_write_data,
  input  logic                              i_write_enable,
  input  logic                              i_write_history_enable
);
  localparam int unsigned IDX_W = SCOREBOARD_ENTRY_INDEX;
  localparam int unsigned RES_W = 2 + IDX_W + LEN_W;

  logic [BEAT_BITS-1:0] head_c;
  logic [BEAT_BITS-1:0] hist_c;
  eq_vec_t              eq_c;

  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic [IDX_W-1:0]     s1_idx_q;

  logic                 cnt_valid_c;
  logic                 cnt_last_c;
  logic [IDX_W-1:0]     cnt_idx_c;
  eq_vec_t              cnt_eq_c;

  logic [RES_W-1:0]     res_d;
  logic [RES_W-1:0]     res_q;
  logic [RES_W-1:0]     out_c;

  match_pe_window_ram #(.SIZE_LOG2(SIZE_LOG2)) u_head_ram (
    .clk         (clk),
    .wr_en_i     (i_write_enable),
    .wr_row_i    (i_write_addr[SIZE_LOG2-1:LANE_W]),
    .wr_data_i   (i_write_data),
    .rd_addr_i   (i_head_addr[SIZE_LOG2-1:0]),
    .rd_data_c_o (head_c)
  );

  match_pe_window_ram #(.SIZE_LOG2(SIZE_LOG2)) u_history_ram (
    .clk         (clk),
    .wr_en_i     (i_write_enable & i_write_history_enable),
    .wr_row_i    (i_write_addr[SIZE_LOG2-1:LANE_W]),
    .wr_data_i   (i_write_data),
    .rd_addr_i   (i_history_addr[SIZE_LOG2-1:0]),
    .rd_data_c_o (hist_c)
  );

  // Stage 1 sideband, aligned with the registered bank reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= i_valid;
      s1_last_q  <= i_last;
      s1_idx_q   <= i_idx;
    end
  end

  always_comb begin
    eq_c = '0;
    for (int unsigned k = 0; k < MATCH_PE_WIDTH; k++) begin
      eq_c[k] = head_c[8*k +: 8] == hist_c[8*k +: 8];
    end
  end

  if (NBPIPE == 2) begin : g_merged
    assign cnt_valid_c = s1_valid_q;
    assign cnt_last_c  = s1_last_q;
    assign cnt_idx_c   = s1_idx_q;
    assign cnt_eq_c    = eq_c;
  end else begin : g_split
    logic             s2_valid_q;
    logic             s2_last_q;
    logic [IDX_W-1:0] s2_idx_q;
    eq_vec_t          s2_eq_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_last_q  <= 1'b0;
        s2_idx_q   <= '0;
        s2_eq_q    <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_idx_q   <= s1_idx_q;
        s2_eq_q    <= eq_c;
      end
    end

    assign cnt_valid_c = s2_valid_q;
    assign cnt_last_c  = s2_last_q;
    assign cnt_idx_c   = s2_idx_q;
    assign cnt_eq_c    = s2_eq_q;
  end

  // Result fields are forced to zero whenever the beat is not valid.
  always_comb begin
    res_d = '0;
    if (cnt_valid_c) begin
      res_d = {1'b1, cnt_last_c, cnt_idx_c, lead_ones(cnt_eq_c)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  if (NBPIPE > 3) begin : g_delay
    localparam int unsigned NDLY = NBPIPE - 3;
    logic [RES_W-1:0] dly_q [NDLY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < NDLY; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q[0] <= res_q;
        for (int unsigned i = 1; i < NDLY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign out_c = dly_q[NDLY-1];
  end else begin : g_nodelay
    assign out_c = res_q;
  end

  assign {o_valid, o_last, o_idx, o_match_len} = out_c;

  // Address bits outside the window and debug tags have no functional use.
  logic unused_bits;
  assign unused_bits = ^{i_head_addr[ADDR_WIDTH-1:SIZE_LOG2],
                         i_history_addr[ADDR_WIDTH-1:SIZE_LOG2],
                         i_write_addr[ADDR_WIDTH-1:SIZE_LOG2],
                         i_write_addr[LANE_W-1:0],
                         LABEL[7:0], 8'(JOB_PE_IDX), 8'(MATCH_PE_IDX)};

`ifdef MATCH_PE_DEBUG_LOG
  always_ff @(posedge clk) begin
    if (o_valid) begin
      $display("[%s job%0d pe%0d] idx=%0d last=%0b len=%0d",
               LABEL, JOB_PE_IDX, MATCH_PE_IDX, o_idx, o_last, o_match_len);
    end
  end
`endif
endmodule

// File: tb/tb_match_pe_pipeline.sv
// Self-checking bench for match_pe_pipeline (W=8, NBPIPE=3) against a byte-array window model.
module tb_match_pe_pipeline;
  import match_pe_pipeline_pkg::*;

  localparam int unsigned SZ = 32768;
  localparam int unsigned AW = ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          i_idx;
  logic          i_last;
  logic [AW-1:0] i_head_addr;
  logic [AW-1:0] i_history_addr;
  logic          o_valid;
  logic          o_last;
  logic          o_idx;
  logic [3:0]    o_match_len;
  logic [AW-1:0] i_write_addr;
  logic [63:0]   i_write_data;
  logic          i_write_enable;
  logic          i_write_history_enable;

  match_pe_pipeline #(
    .SCOREBOARD_ENTRY_INDEX(1),
    .NBPIPE(3),
    .SIZE_LOG2(15)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_valid                (i_valid),
    .i_idx                  (i_idx),
    .i_last                 (i_last),
    .i_head_addr            (i_head_addr),
    .i_history_addr         (i_history_addr),
    .o_valid                (o_valid),
    .o_last                 (o_last),
    .o_idx                  (o_idx),
    .o_match_len            (o_match_len),
    .i_write_addr           (i_write_addr),
    .i_write_data           (i_write_data),
    .i_write_enable         (i_write_enable),
    .i_write_history_enable (i_write_history_enable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] head_m [SZ];
  logic [7:0] hist_m [SZ];

  typedef struct {
    bit v;
    bit last;
    bit idx;
    int len;
  } exp_t;

  function automatic int ref_len(input int unsigned h, input int unsigned y);
    for (int k = 0; k < 8; k++) begin
      if (head_m[(h + k) % SZ] != hist_m[(y + k) % SZ]) return k;
    end
    return 8;
  endfunction

  function automatic void model_write(input int unsigned addr, input logic [63:0] data, input bit hist);
    int unsigned base;
    base = (addr & 32'hFFFF_FFF8) % SZ;
    for (int k = 0; k < 8; k++) begin
      head_m[base + k] = data[8*k +: 8];
      if (hist) hist_m[base + k] = data[8*k +: 8];
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_beat();
    i_valid        = 1'b0;
    i_idx          = 1'b0;
    i_last         = 1'b0;
    i_head_addr    = '0;
    i_history_addr = '0;
  endtask

  task automatic idle_all();
    idle_beat();
    i_write_enable         = 1'b0;
    i_write_history_enable = 1'b0;
    i_write_addr           = '0;
    i_write_data           = '0;
  endtask

  task automatic drive_beat(input int unsigned h, input int unsigned y, input bit idx, input bit last);
    i_valid        = 1'b1;
    i_idx          = idx;
    i_last         = last;
    i_head_addr    = AW'(h);
    i_history_addr = AW'(y);
  endtask

  task automatic write_cycle(input int unsigned addr, input logic [63:0] data, input bit hist);
    i_write_enable         = 1'b1;
    i_write_history_enable = hist;
    i_write_addr           = AW'(addr);
    i_write_data           = data;
    step();
    model_write(addr, data, hist);
    i_write_enable         = 1'b0;
    i_write_history_enable = 1'b0;
  endtask

  // Single beat, then wait until it reaches the outputs.
  task automatic issue_wait(input int unsigned h, input int unsigned y, input bit idx, input bit last);
    drive_beat(h, y, idx, last);
    step();
    idle_beat();
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%b exp=0", o_valid);
    end
    n_cmp++;
    if ({o_last, o_idx, o_match_len} !== 6'd0) begin
      n_bad++; $display("FAIL reset_fields got=%b/%b/%0d exp=0/0/0", o_last, o_idx, o_match_len);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=0", c, o_valid);
      end
    end
  endtask

  task automatic test_fill_basic();
    write_cycle(0, 64'h0706050403020100, 1'b1);
    write_cycle(8, 64'h0F0E0D0C0B0A0908, 1'b1);
    drive_beat(0, 0, 1'b1, 1'b1);
    step();
    idle_beat();
    step();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_early got=%b exp=0", o_valid);
    end
    step();
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_valid got=%b exp=1", o_valid);
    end
    n_cmp++;
    if (o_match_len !== 4'd8) begin
      n_bad++; $display("FAIL basic_len got=%0d exp=8", o_match_len);
    end
    n_cmp++;
    if ({o_idx, o_last} !== 2'b11) begin
      n_bad++; $display("FAIL basic_sideband got=%b%b exp=11", o_idx, o_last);
    end
    step();
    n_cmp++;
    if ({o_valid, o_last, o_idx, o_match_len} !== 7'd0) begin
      n_bad++; $display("FAIL basic_after got=%b/%0d exp=0/0", o_valid, o_match_len);
    end
  endtask

  task automatic test_history_only();
    write_cycle(0, 64'h0706FF0403020100, 1'b1);
    write_cycle(0, 64'h0706050403020100, 1'b0);
    issue_wait(0, 0, 1'b0, 1'b0);
    n_cmp++;
    if ({o_valid, o_match_len} !== {1'b1, 4'd5}) begin
      n_bad++; $display("FAIL hist_only got=%b/%0d exp=1/5", o_valid, o_match_len);
    end
  endtask

  task automatic test_unaligned();
    write_cycle(0, 64'h0706050403020100, 1'b1);
    issue_wait(3, 3, 1'b1, 1'b0);
    n_cmp++;
    if ({o_valid, o_idx, o_match_len} !== {1'b1, 1'b1, 4'd8}) begin
      n_bad++; $display("FAIL unaligned_eq got=%b/%b/%0d exp=1/1/8", o_valid, o_idx, o_match_len);
    end
    issue_wait(1, 2, 1'b0, 1'b1);
    n_cmp++;
    if ({o_valid, o_last, o_match_len} !== {1'b1, 1'b1, 4'd0}) begin
      n_bad++; $display("FAIL unaligned_ne got=%b/%b/%0d exp=1/1/0", o_valid, o_last, o_match_len);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned hs[3] = '{0, 1, 4};
    int unsigned ys[3] = '{0, 2, 4};
    bit ix[3] = '{1'b0, 1'b1, 1'b0};
    bit ls[3] = '{1'b0, 1'b0, 1'b1};
    int el[3];
    for (int b = 0; b < 3; b++) el[b] = ref_len(hs[b], ys[b]);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive_beat(hs[c], ys[c], ix[c], ls[c]);
      else idle_beat();
      step();
      if (c >= 2) begin
        int b;
        logic [6:0] exp_v;
        b = c - 2;
        exp_v = (b < 3) ? {1'b1, ls[b], ix[b], 4'(el[b])} : 7'd0;
        n_cmp++;
        if ({o_valid, o_last, o_idx, o_match_len} !== exp_v) begin
          n_bad++;
          $display("FAIL b2b slot=%0d got v=%b l=%b i=%b len=%0d exp v=%b l=%b i=%b len=%0d",
                   b, o_valid, o_last, o_idx, o_match_len, exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    write_cycle(SZ + 8, 64'h1122334455667788, 1'b1);
    write_cycle(24, 64'h1122334455667788, 1'b1);
    issue_wait(8, 24, 1'b0, 1'b0);
    n_cmp++;
    if ({o_valid, o_match_len} !== {1'b1, 4'd8}) begin
      n_bad++; $display("FAIL wrap_write got=%b/%0d exp=1/8", o_valid, o_match_len);
    end
    write_cycle(SZ - 8, 64'hA7A6A5A4A3A2A1A0, 1'b1);
    write_cycle(32, 64'h03020100A7A6A5A4, 1'b1);
    issue_wait(SZ - 4, 32, 1'b0, 1'b0);
    n_cmp++;
    if ({o_valid, o_match_len} !== {1'b1, 4'd8}) begin
      n_bad++; $display("FAIL wrap_read_head got=%b/%0d exp=1/8", o_valid, o_match_len);
    end
    issue_wait(32, 5 * SZ + SZ - 4, 1'b1, 1'b0);
    n_cmp++;
    if ({o_valid, o_idx, o_match_len} !== {1'b1, 1'b1, 4'd8}) begin
      n_bad++; $display("FAIL wrap_read_hist got=%b/%b/%0d exp=1/1/8", o_valid, o_idx, o_match_len);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    exp_t g;
    for (int r = 2; r < 32; r++) write_cycle(r * 8, {$urandom, $urandom}, 1'b1);
    for (int c = 0; c < 403; c++) begin
      int unsigned h, y, r, j;
      logic [63:0] d;
      bit hb;
      idle_all();
      e.v = 1'b0; e.last = 1'b0; e.idx = 1'b0; e.len = 0;
      if (c < 400 && $urandom_range(0, 3) != 0) begin
        h = $urandom_range(0, 247);
        y = ($urandom_range(0, 3) != 0) ? h : $urandom_range(0, 247);
        e.v    = 1'b1;
        e.last = 1'($urandom_range(0, 1));
        e.idx  = 1'($urandom_range(0, 1));
        e.len  = ref_len(h, y);
        drive_beat(h, y, e.idx, e.last);
        i_head_addr    = AW'(h) | (AW'($urandom) << 15);
        i_history_addr = AW'(y) | (AW'($urandom) << 15);
      end
      if (c < 400 && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 31);
        for (int k = 0; k < 8; k++) d[8*k +: 8] = head_m[r * 8 + k];
        hb = 1'($urandom_range(0, 1));
        if (!hb) begin
          j = $urandom_range(0, 7);
          d[8*j +: 8] = 8'($urandom);
        end
        i_write_enable         = 1'b1;
        i_write_history_enable = hb;
        i_write_data           = d;
        i_write_addr           = AW'(r * 8 + $urandom_range(0, 7)) | (AW'($urandom) << 15);
        model_write(i_write_addr, d, hb);
      end
      q.push_back(e);
      step();
      if (q.size() == 3) begin
        g = q.pop_front();
        n_cmp++;
        if ({o_valid, o_last, o_idx, o_match_len} !== {g.v, g.last, g.idx, 4'(g.len)}) begin
          n_bad++;
          $display("FAIL random cyc=%0d got v=%b l=%b i=%b len=%0d exp v=%b l=%b i=%b len=%0d",
                   c, o_valid, o_last, o_idx, o_match_len, g.v, g.last, g.idx, g.len);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_reset_midstream();
    int el;
    for (int c = 0; c < 4; c++) begin
      drive_beat(0, 0, 1'b1, 1'b1);
      step();
    end
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_bad++; $display("FAIL midstream_pre got=%b exp=1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_last, o_idx, o_match_len} !== 7'd0) begin
      n_bad++; $display("FAIL midstream_async got=%b/%b/%b/%0d exp=0/0/0/0", o_valid, o_last, o_idx, o_match_len);
    end
    idle_all();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL midstream_stale cyc=%0d got=%b exp=0", c, o_valid);
      end
    end
    el = ref_len(8, 24);
    issue_wait(8, 24, 1'b1, 1'b0);
    n_cmp++;
    if ({o_valid, o_idx, o_last, o_match_len} !== {1'b1, 1'b1, 1'b0, 4'(el)}) begin
      n_bad++; $display("FAIL midstream_resume got=%b/%0d exp=1/%0d", o_valid, o_match_len, el);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill_basic();
    test_history_only();
    test_unaligned();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
